// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath on unsigned magnitudes: shift-add multiply (LSB first) and
// restoring divide (MSB first). Next-iteration values are exposed combinationally.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] prod_next_o,
    output logic [XLEN-1:0]   quo_next_o,
    output logic [XLEN-1:0]   rem_next_o
);

    // acc_q: {partial product, multiplier} for multiply; low half is the
    // dividend shifting out / quotient shifting in for divide.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              div_q, div_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic              div_neg;

    always_comb begin
        mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        prod_next_o = {mul_sum, acc_q[XLEN-1:1]};

        div_shift   = {rem_q, acc_q[XLEN-1]};
        div_trial   = div_shift - {1'b0, opb_q};
        div_neg     = div_trial[XLEN];
        quo_next_o  = {acc_q[XLEN-2:0], ~div_neg};
        rem_next_o  = div_neg ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
    end

    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        opb_d = opb_q;
        div_d = div_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, (is_div_i ? a_i : b_i)};
            opb_d = is_div_i ? b_i : a_i;
            rem_d = '0;
            div_d = is_div_i;
        end else if (step_i) begin
            if (div_q) begin
                acc_d = {acc_q[2*XLEN-1:XLEN], quo_next_o};
                rem_d = rem_next_o;
            end else begin
                acc_d = prod_next_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q <= '0;
            rem_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            opb_q <= opb_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: captures an M-extension op, stalls the CPU while the
// iterative core runs, then pulses a one-cycle write-enable with the result.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ITERS = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            wb_en_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              signed_a, signed_b, a_neg, b_neg, is_div;
    logic              div_by_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, div_val, final_res;
    logic [2*XLEN-1:0] prod_next, prod_fix;
    logic [XLEN-1:0]   quo_next, rem_next;
    logic              core_load, core_step;

    always_comb begin
        signed_a    = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        signed_b    = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        a_neg       = signed_a & rs1_i[XLEN-1];
        b_neg       = signed_b & rs2_i[XLEN-1];
        a_mag       = a_neg ? -rs1_i : rs1_i;
        b_mag       = b_neg ? -rs2_i : rs2_i;
        is_div      = funct3_i[2];
        div_by_zero = is_div && (rs2_i == '0);
        div_ovf     = is_div && !funct3_i[0] && (rs2_i == '1) &&
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
        // Divide-by-zero and signed overflow bypass the loop with RISC-V defined results.
        if (div_by_zero) begin
            special_res = funct3_i[1] ? rs1_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : rs1_i;
        end

        prod_fix  = neg_q ? -prod_next : prod_next;
        div_val   = f3_q[1] ? rem_next : quo_next;
        if (f3_q[2]) begin
            final_res = neg_q ? -div_val : div_val;
        end else if (f3_q == F3_MUL) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    f3_d  = funct3_i;
                    // Remainder takes the dividend's sign; everything else the XOR.
                    neg_d = (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
                    if (div_by_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        core_load = 1'b1;
                        cnt_d     = CW'(ITERS - 1);
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                core_step = 1'b1;
                if (cnt_q == '0) begin
                    result_d = final_res;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (core_load),
        .step_i      (core_step),
        .is_div_i    (is_div),
        .a_i         (a_mag),
        .b_i         (b_mag),
        .prod_next_o (prod_next),
        .quo_next_o  (quo_next),
        .rem_next_o  (rem_next)
    );

    assign stall_o  = rst_i & req_i & (state_q != DONE);
    assign done_o   = (state_q == DONE);
    assign wb_en_o  = done_o;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window, results and reset.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        done;
    logic        wb_en;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req_i    (req),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .stall_o  (stall),
        .done_o   (done),
        .wb_en_o  (wb_en),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of cycle 0 with the request already driven.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int  cyc = 0;
        int  stall_cnt = 0;
        bit  seen = 1'b0;
        while (!seen && cyc <= 100) begin
            #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (stall) stall_cnt++;
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_wb_en"}, 32'(wb_en), 32'd1);
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        $display("op %s: rs1=%h rs2=%h f3=%0d result=%h latency=%0d stall_cycles=%0d",
                 tag, rs1, rs2, funct3, result, cyc, stall_cnt);
        req = 1'b0;
    endtask

    // Issues in the cycle right after the previous call's DONE cycle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        @(posedge clk);
        @(negedge clk);
        req    = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        wait_done(tag, exp_res, exp_lat);
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 1'b1;
        funct3 = 3'd0;
        rs1    = 32'd0;
        rs2    = 32'd0;

        #12;
        check("rst_stall_forced_low", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_result", result, 32'd0);
        $display("reset: stall=%b done=%b wb_en=%b result=%h", stall, done, wb_en, result);

        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
        #1;
        check("idle_no_req_stall", 32'(stall), 32'd0);

        run_op("mul_7_m3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulhu_m1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulh_m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu_7_2",   3'b101, 32'd7,        32'd2,        32'd3,        33);
        run_op("remu_7_2",   3'b111, 32'd7,        32'd2,        32'd1,        33);
        run_op("div_5_0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_5_0",    3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("divu_5_0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("b2b_mul_3_4",  3'b000, 32'd3,   32'd4, 32'd12, 33);
        run_op("b2b_divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Reset during BUSY cycle 10 of MUL 7*3.
        @(posedge clk);
        @(negedge clk);
        req    = 1'b1;
        funct3 = 3'b000;
        rs1    = 32'd7;
        rs2    = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("busy_result_hold", result, 32'd14);
        check("busy_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        $display("mid-op reset: stall=%b done=%b result=%h", stall, done, result);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_wb_pulse", 32'(wb_en), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("mul_after_rst", 32'd21, 33);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
